// File: rtl/range_pkg.sv
// Shared types and default widths for the range finder datapath and its frame generator.
package range_pkg;

    localparam int RANGE_WIDTH = 8;
    localparam int RANGE_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock sample FIFO with registered pointers; head shows the oldest entry, no bypass.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_push;
    logic             do_pop;

    // Requests against a full/empty FIFO are dropped here, so callers may push/pop freely.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (occ == FULL_OCC);
    assign empty   = (occ == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/range_frame_gen.sv
// Buffers upstream samples and replays them to the range finder as framed bursts with go/finish strobes.
module range_frame_gen
    import range_pkg::*;
#(
    parameter int WIDTH = RANGE_WIDTH,
    parameter int DEPTH = 4,
    parameter int LEN_W = RANGE_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic [WIDTH-1:0] data_out,
    output logic             go,
    output logic             finish,
    output logic             busy,
    output logic             err,
    output state_t           dbg_state
);

    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] count;
    logic [WIDTH-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready; in_ready is just "FIFO not full".
    assign in_ready  = !fifo_full;
    assign fifo_pop  = (state != IDLE) && !fifo_empty;
    assign dbg_state = state;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len      <= '0;
            count    <= '0;
            data_out <= '0;
            go       <= 1'b0;
            finish   <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            go     <= 1'b0;
            finish <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (frame_len >= LEN_MIN) begin
                            state <= ARMED;
                            len   <= frame_len;
                            count <= '0;
                            busy  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (start) err <= 1'b1;
                    if (!fifo_empty) begin
                        data_out <= fifo_head;
                        go       <= 1'b1;
                        count    <= LEN_W'(1);
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (start) err <= 1'b1;
                    // An empty FIFO stalls the frame; data_out holds so a repeat cannot move min/max.
                    if (!fifo_empty) begin
                        data_out <= fifo_head;
                        count    <= count + 1'b1;
                        if (count == len - 1'b1) begin
                            finish <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_frame_gen.sv
// Scenario bench for range_frame_gen: expected frame samples are queued as stimulus is driven and matched by a monitor.
module tb_range_frame_gen;
    import range_pkg::*;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int LEN_W   = 8;
    localparam int W       = WIDTH + 2;
    localparam int TIMEOUT = 400;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             start = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic [WIDTH-1:0] data_out;
    logic             go;
    logic             finish;
    logic             busy;
    logic             err;
    state_t           dbg_state;

    int checks = 0;
    int errors = 0;
    int n_go = 0;
    int n_finish = 0;
    logic [W-1:0]     exp_q[$];
    logic             in_frame = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    range_frame_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .frame_len(frame_len), .data_out(data_out), .go(go), .finish(finish),
        .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "global timeout");
    end

    // scoreboard monitor: every new output sample is matched against {go, finish, data} from exp_q
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            in_frame  = 1'b0;
            prev_data = data_out;
        end else begin
            checks++;
            if (go && finish) begin
                errors++;
                $display("FAIL go_finish_overlap: go=%b finish=%b required not both 1", go, finish);
            end
            checks++;
            if (finish && busy) begin
                errors++;
                $display("FAIL busy_at_finish: busy=%b required 0", busy);
            end
            if (go) n_go++;
            if (finish) n_finish++;
            if (go || finish || (in_frame && data_out != prev_data)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample: go=%b finish=%b data_out=%0d required no output", go, finish, data_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({go, finish, data_out} !== e) begin
                        errors++;
                        $display("FAIL sample: go=%b finish=%b data_out=%0d required go=%b finish=%b data_out=%0d",
                                 go, finish, data_out, e[W-1], e[W-2], e[WIDTH-1:0]);
                    end
                end
            end else if (!in_frame) begin
                checks++;
                if (data_out !== prev_data) begin
                    errors++;
                    $display("FAIL idle_hold: data_out=%0d required %0d", data_out, prev_data);
                end
            end
            if (go) in_frame = 1'b1;
            if (finish) in_frame = 1'b0;
            prev_data = data_out;
        end
    end

    // driver tasks (all start and end 1 time unit after a rising edge)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sample(input logic first, input logic last, input logic [WIDTH-1:0] d);
        exp_q.push_back({first, last, d});
    endtask

    task automatic push_sample(input logic [WIDTH-1:0] d);
        int tries = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && tries < TIMEOUT) begin
            tries++;
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [LEN_W-1:0] len);
        start     = 1'b1;
        frame_len = len;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < TIMEOUT) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
        step();
    endtask

    task automatic check_frames(input string name, input int g0, input int f0, input int frames);
        checks++;
        if (n_go !== g0 + frames || n_finish !== f0 + frames) begin
            errors++;
            $display("FAIL %s_pulses: go_count=%0d finish_count=%0d required %0d each", name, n_go - g0, n_finish - f0, frames);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %0d required 0", data_out); end
        checks++; if (go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b required 0", go); end
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b required 0", finish); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_prefill();
        int g0 = n_go;
        int f0 = n_finish;
        expect_sample(1'b1, 1'b0, 8'd10);
        expect_sample(1'b0, 1'b0, 8'd20);
        expect_sample(1'b0, 1'b0, 8'd5);
        expect_sample(1'b0, 1'b1, 8'd30);
        push_sample(8'd10);
        push_sample(8'd20);
        push_sample(8'd5);
        push_sample(8'd30);
        do_start(8'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prefill_busy: got %b required 1", busy); end
        wait_idle();
        check_frames("prefill", g0, f0, 1);
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL prefill_state: got %0d required %0d", dbg_state, IDLE); end
    endtask

    task automatic test_slow();
        logic [WIDTH-1:0] vals [3];
        int g0 = n_go;
        int f0 = n_finish;
        vals[0] = 8'd7;
        vals[1] = 8'd9;
        vals[2] = 8'd8;
        for (int i = 0; i < 3; i++) expect_sample(i == 0, i == 2, vals[i]);
        do_start(8'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            step();
            push_sample(vals[i]);
        end
        wait_idle();
        check_frames("slow", g0, f0, 1);
    endtask

    task automatic test_bad_len();
        logic [LEN_W-1:0] lens [2];
        int g0 = n_go;
        lens[0] = 8'd1;
        lens[1] = 8'd0;
        for (int i = 0; i < 2; i++) begin
            do_start(lens[i]);
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_len_err: len=%0d err=%b required 1", lens[i], err); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_len_busy: len=%0d busy=%b required 0", lens[i], busy); end
            checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL bad_len_state: got %0d required %0d", dbg_state, IDLE); end
            step();
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_len_err_pulse: err=%b required 0", err); end
        end
        checks++; if (n_go !== g0) begin errors++; $display("FAIL bad_len_go: go_count=%0d required 0", n_go - g0); end
    endtask

    task automatic test_full();
        int g0 = n_go;
        int f0 = n_finish;
        expect_sample(1'b1, 1'b0, 8'd11);
        expect_sample(1'b0, 1'b1, 8'd12);
        expect_sample(1'b1, 1'b0, 8'd13);
        expect_sample(1'b0, 1'b0, 8'd14);
        expect_sample(1'b0, 1'b1, 8'd15);
        for (int i = 11; i <= 14; i++) push_sample(WIDTH'(i));
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
            step();
        end
        fork
            push_sample(8'd15);
            do_start(8'd2);
        join
        wait_idle();
        do_start(8'd3);
        wait_idle();
        check_frames("full", g0, f0, 2);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vals [6];
        logic [WIDTH-1:0] v = '0;
        int g0 = n_go;
        int f0 = n_finish;
        for (int i = 0; i < 6; i++) begin
            do v = WIDTH'($urandom_range(1, 255)); while (v == prev_data_pick(vals, i));
            vals[i] = v;
            expect_sample(i == 0, i == 5, v);
        end
        do_start(8'd6);
        for (int i = 0; i < 6; i++) push_sample(vals[i]);
        wait_idle();
        check_frames("back_to_back", g0, f0, 1);
    endtask

    function automatic logic [WIDTH-1:0] prev_data_pick(input logic [WIDTH-1:0] vals [6], input int i);
        return (i == 0) ? '0 : vals[i-1];
    endfunction

    task automatic test_long();
        int g0 = n_go;
        int f0 = n_finish;
        for (int i = 0; i < 255; i++) expect_sample(i == 0, i == 254, WIDTH'(i));
        do_start(8'd255);
        for (int i = 0; i < 255; i++) push_sample(WIDTH'(i));
        wait_idle();
        check_frames("long", g0, f0, 1);
    endtask

    task automatic test_reset_mid();
        int f0 = n_finish;
        int g0;
        expect_sample(1'b1, 1'b0, 8'd40);
        expect_sample(1'b0, 1'b0, 8'd41);
        do_start(8'd5);
        push_sample(8'd40);
        push_sample(8'd41);
        step();
        step();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_pre_reset: pending=%0d required 0", exp_q.size()); end
        push_sample(8'd42);
        rst_n = 1'b0;
        #1;
        checks++; if (data_out !== '0) begin errors++; $display("FAIL mid_data_out: got %0d required 0", data_out); end
        checks++; if ({go, finish, busy, err} !== 4'b0000) begin errors++; $display("FAIL mid_flags: go/finish/busy/err=%b required 0000", {go, finish, busy, err}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b required 1", in_ready); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL mid_state: got %0d required %0d", dbg_state, IDLE); end
        step();
        rst_n = 1'b1;
        checks++; if (n_finish !== f0) begin errors++; $display("FAIL mid_no_finish: finish_count=%0d required 0", n_finish - f0); end
        g0 = n_go;
        f0 = n_finish;
        expect_sample(1'b1, 1'b0, 8'd50);
        expect_sample(1'b0, 1'b1, 8'd51);
        do_start(8'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_first_start: busy=%b required 1", busy); end
        push_sample(8'd50);
        push_sample(8'd51);
        wait_idle();
        check_frames("after_reset", g0, f0, 1);
    endtask

    task automatic test_start_during_stream();
        int g0 = n_go;
        int f0 = n_finish;
        expect_sample(1'b1, 1'b0, 8'd60);
        expect_sample(1'b0, 1'b0, 8'd61);
        expect_sample(1'b0, 1'b1, 8'd62);
        push_sample(8'd60);
        push_sample(8'd61);
        do_start(8'd3);
        step();
        do_start(8'd2);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL stream_err: got %b required 1", err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy: got %b required 1", busy); end
        checks++; if (dbg_state !== STREAM) begin errors++; $display("FAIL stream_state: got %0d required %0d", dbg_state, STREAM); end
        push_sample(8'd62);
        wait_idle();
        check_frames("stream_start", g0, f0, 1);
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_slow();
        test_bad_len();
        test_full();
        test_back_to_back();
        test_start_during_stream();
        test_long();
        test_reset_mid();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: pending=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/range_frame_gen.md
RANGE_FRAME_GEN -- requirements
Module: range_frame_gen

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits; SHALL equal the range finder data width.
REQ-002 Parameter DEPTH, default 4, sample FIFO entries (power of two, >=2).
REQ-003 Parameter LEN_W, default 8, width of frame_len and the sample counter.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  WIDTH  upstream sample.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  FIFO can accept; a sample transfers when in_valid && in_ready.
REQ-009 start  input  1  one-cycle request to begin a frame.
REQ-010 frame_len  input  LEN_W  samples per frame; SHALL be captured only on an accepted start.
REQ-011 data_out  output  WIDTH  sample to the range finder's data input.
REQ-012 go  output  1  one-cycle pulse coincident with the first frame sample.
REQ-013 finish  output  1  one-cycle pulse coincident with the last frame sample.
REQ-014 busy  output  1  high from accepted start until the cycle finish is driven.
REQ-015 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 FIFO SHALL accept samples in every state; in_ready = not full; no drop, no overwrite.
REQ-017 FSM states SHALL be IDLE, ARMED, STREAM.
REQ-018 IDLE: start with frame_len>=2 -> ARMED, capture len, clear count, busy=1.
REQ-019 IDLE: start with frame_len<2 -> stay IDLE, err=1 next cycle, no capture.
REQ-020 start in ARMED or STREAM SHALL be ignored and pulse err; frame continues unaffected.
REQ-021 ARMED: FIFO non-empty -> pop, data_out<=head, go<=1, count<=1, -> STREAM.
REQ-022 STREAM: FIFO non-empty -> pop, data_out<=head, count<=count+1; if count==len-1, finish<=1 and -> IDLE with busy<=0.
REQ-023 data_out, go, finish SHALL be registered: one cycle after the pop decision; no FIFO bypass (push to empty FIFO is poppable the following cycle).
REQ-024 FIFO empty in ARMED/STREAM: no pop, go=finish=0, data_out SHALL hold last value (repeat cannot change min/max downstream).
REQ-025 Push and pop in the same cycle SHALL be supported for non-empty, non-full FIFO; occupancy unchanged.
REQ-026 go and finish SHALL never be high in the same cycle; exactly one go and one finish per accepted frame.
REQ-027 Pointer arithmetic SHALL wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-028 frame_len max 2^LEN_W-1 SHALL be supported without counter overflow.

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE, FIFO empty, count 0, len 0, data_out 0, go 0, finish 0, busy 0, err 0, in_ready 1.
REQ-030 Reset mid-frame SHALL discard the frame and buffered samples; no finish emitted.
REQ-031 Release SHALL be synchronous to clk; first start honoured on the first edge after release.

Structure
REQ-032 Package range_pkg SHALL hold the FSM state type and default WIDTH/LEN_W constants, shared with the range finder top.
REQ-033 FIFO SHALL be a sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/head); FSM and counter in range_frame_gen.

Verification
REQ-034 Prefill 10,20,5,30; start len=4 -> go with data_out=10, then 20,5, finish with 30; busy low after finish.
REQ-035 start len=3, samples 7,9,8 arriving every third cycle -> data_out holds between pops, go on 7, finish on 8, no extra pulses.
REQ-036 start len=1 and len=0 -> err pulse each, busy stays 0, no go.
REQ-037 Push 5 samples with no start, DEPTH=4 -> in_ready low after 4th, 5th held until start len=2 pops.
REQ-038 start len=5, rst_n low after 2 samples -> all outputs 0 asynchronously, FIFO empty, no finish.
REQ-039 start during STREAM -> err pulse, current frame finishes with original length.
